apb_master_arbiter: RTL and testbench

APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

---
 rtl/apb_arb_pkg.sv | 12 +
 rtl/apb_arb_rr_pick.sv | 26 ++
 rtl/apb_master_arbiter.sv | 145 ++++++++++++++
 tb/tb_apb_master_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB master arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } arb_state_e;

    localparam int TIMEOUT_CNT_W = 16;

endpackage

// File: rtl/apb_arb_rr_pick.sv
// Combinational round-robin pick: the first requester after last_grant wins,
// with the search wrapping modulo NUM_MASTERS.
module apb_arb_rr_pick #(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       last_grant,
    output logic                   valid,
    output logic [IDX_W-1:0]       winner
);

    // Walk from the farthest candidate down to the nearest so the nearest requester overrides
    always_comb begin
        int idx;
        idx    = 0;
        valid  = 1'b0;
        winner = '0;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            idx    = (int'(last_grant) + i) % NUM_MASTERS;
            valid  = valid | req[idx];
            winner = req[idx] ? IDX_W'(idx) : winner;
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// N-to-1 APB requester arbiter with round-robin grant.
// Optional access-phase timeout enabled by defining APB_ARB_TIMEOUT_EN.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                         clk,
    input  logic                                         rstn,
    input  logic [NUM_MASTERS-1:0]                       m_psel,
    input  logic [NUM_MASTERS-1:0]                       m_penable,
    input  logic [NUM_MASTERS-1:0]                       m_pwrite,
    input  logic [NUM_MASTERS-1:0][APB_ADDR_WIDTH-1:0]   m_paddr,
    input  logic [NUM_MASTERS-1:0][31:0]                 m_pwdata,
    output logic [31:0]                                  m_prdata,
    output logic [NUM_MASTERS-1:0]                       m_pready,
    output logic [NUM_MASTERS-1:0]                       m_pslverr,
    output logic                                         psel,
    output logic                                         penable,
    output logic                                         pwrite,
    output logic [APB_ADDR_WIDTH-1:0]                    paddr,
    output logic [31:0]                                  pwdata,
    input  logic [31:0]                                  prdata,
    input  logic                                         pready,
    input  logic                                         pslverr
);

    localparam int IDX_W = $clog2(NUM_MASTERS);

    arb_state_e        state_r;
    logic [IDX_W-1:0]  grant_r;
    logic [IDX_W-1:0]  last_grant_r;
    logic              pick_valid_s;
    logic [IDX_W-1:0]  pick_winner_s;
    logic              timeout_hit_s;
    logic              penable_unused_s;

    // Masters' own penable carries no arbitration information
    assign penable_unused_s = ^m_penable;

    apb_arb_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_rr_pick (
        .req        (m_psel),
        .last_grant (last_grant_r),
        .valid      (pick_valid_s),
        .winner     (pick_winner_s)
    );

`ifdef APB_ARB_TIMEOUT_EN
    logic [TIMEOUT_CNT_W-1:0] wait_cnt_r;

    // Count access-phase wait cycles of the current transfer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt_r <= '0;
        end else if (state_r == SETUP) begin
            wait_cnt_r <= '0;
        end else if ((state_r == ACCESS) && !pready) begin
            wait_cnt_r <= wait_cnt_r + TIMEOUT_CNT_W'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // The limit-th wait cycle itself is the abort cycle
    assign timeout_hit_s = (state_r == ACCESS) && !pready &&
                           (wait_cnt_r == TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic timeout_unused_s;
    assign timeout_unused_s = (TIMEOUT_CYCLES < (1 << TIMEOUT_CNT_W));
    assign timeout_hit_s    = 1'b0;
`endif

    // Transfer sequencing and grant bookkeeping
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= IDLE;
            grant_r      <= '0;
            last_grant_r <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_valid_s) begin
                        grant_r      <= pick_winner_s;
                        last_grant_r <= pick_winner_s;
                        state_r      <= SETUP;
                    end else begin
                        state_r      <= IDLE;
                    end
                end
                SETUP: begin
                    state_r <= ACCESS;
                end
                ACCESS: begin
                    if (pready || timeout_hit_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= ACCESS;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign psel     = (state_r != IDLE);
    assign penable  = (state_r == ACCESS);
    assign m_prdata = prdata;

    // Forward the granted master's request while a transfer is in flight
    always_comb begin
        paddr  = '0;
        pwrite = 1'b0;
        pwdata = '0;
        if (state_r != IDLE) begin
            paddr  = m_paddr[grant_r];
            pwrite = m_pwrite[grant_r];
            pwdata = m_pwdata[grant_r];
        end else begin
            paddr  = '0;
            pwrite = 1'b0;
            pwdata = '0;
        end
    end

    // Route the completion/error back to the granted master only
    always_comb begin
        m_pready  = '0;
        m_pslverr = '0;
        if (state_r == ACCESS) begin
            m_pready[grant_r]  = pready | timeout_hit_s;
            m_pslverr[grant_r] = (pslverr & pready) | timeout_hit_s;
        end else begin
            m_pready  = '0;
            m_pslverr = '0;
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: directed scenarios plus a random
// phase, all compared against a transaction-level reference model.
module tb_apb_master_arbiter;

    localparam int NM = 3;
    localparam int AW = 12;
    localparam int TO = 4;

    logic                        clk;
    logic                        rstn;
    logic [NM-1:0]               m_psel;
    logic [NM-1:0]               m_penable;
    logic [NM-1:0]               m_pwrite;
    logic [NM-1:0][AW-1:0]       m_paddr;
    logic [NM-1:0][31:0]         m_pwdata;
    logic [31:0]                 m_prdata;
    logic [NM-1:0]               m_pready;
    logic [NM-1:0]               m_pslverr;
    logic                        psel;
    logic                        penable;
    logic                        pwrite;
    logic [AW-1:0]               paddr;
    logic [31:0]                 pwdata;
    logic [31:0]                 prdata;
    logic                        pready;
    logic                        pslverr;

    apb_master_arbiter #(
        .NUM_MASTERS    (NM),
        .APB_ADDR_WIDTH (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .m_psel    (m_psel),
        .m_penable (m_penable),
        .m_pwrite  (m_pwrite),
        .m_paddr   (m_paddr),
        .m_pwdata  (m_pwdata),
        .m_prdata  (m_prdata),
        .m_pready  (m_pready),
        .m_pslverr (m_pslverr),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: who owns the bus, which phase, how many waits so far
    int mdl_last;
    int mdl_cur;
    int mdl_phase;   // 0 no transfer, 1 setup, 2 access
    int mdl_wait;
    int remaining[NM];
    int order_q[$];
    int done_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit mdl_timeout();
`ifdef APB_ARB_TIMEOUT_EN
        return (mdl_phase == 2) && !pready && (mdl_wait == TO - 1);
`else
        return 1'b0;
`endif
    endfunction

    task automatic mdl_reset();
        mdl_last  = NM - 1;
        mdl_cur   = 0;
        mdl_phase = 0;
        mdl_wait  = 0;
    endtask

    task automatic new_payload(input int i);
        m_pwrite[i] = 1'($urandom_range(0, 1));
        m_paddr[i]  = AW'($urandom);
        m_pwdata[i] = $urandom;
    endtask

    task automatic master_done(input int i);
        if (remaining[i] > 1) begin
            remaining[i]--;
            new_payload(i);
        end else begin
            remaining[i] = 0;
            m_psel[i]    = 1'b0;
        end
    endtask

    task automatic set_slave(input logic rdy, input logic err, input logic [31:0] rd);
        pready  = rdy;
        pslverr = err;
        prdata  = rd;
    endtask

    // Compare every DUT output against the model for the current cycle
    task automatic check_cycle();
        logic [NM-1:0] er;
        logic [NM-1:0] ee;
        logic [AW-1:0] ea;
        logic [31:0]   ed;
        logic          ew;
        #1;
        er = '0; ee = '0; ea = '0; ed = '0; ew = 1'b0;
        if (mdl_phase != 0) begin
            ea = m_paddr[mdl_cur];
            ed = m_pwdata[mdl_cur];
            ew = m_pwrite[mdl_cur];
        end
        if (mdl_phase == 2) begin
            er[mdl_cur] = pready || mdl_timeout();
            ee[mdl_cur] = (pready && pslverr) || mdl_timeout();
        end
        chk("psel",      64'(psel),      64'(mdl_phase != 0));
        chk("penable",   64'(penable),   64'(mdl_phase == 2));
        chk("paddr",     64'(paddr),     64'(ea));
        chk("pwdata",    64'(pwdata),    64'(ed));
        chk("pwrite",    64'(pwrite),    64'(ew));
        chk("m_prdata",  64'(m_prdata),  64'(prdata));
        chk("m_pready",  64'(m_pready),  64'(er));
        chk("m_pslverr", 64'(m_pslverr), 64'(ee));
        for (int i = 0; i < NM; i++) begin
            if (m_pready[i]) begin
                order_q.push_back(i);
                done_q.push_back(cyc);
            end
        end
    endtask

    // Advance the model across the coming clock edge using pre-edge inputs
    task automatic mdl_step();
        bit found;
        int c;
        found = 1'b0;
        if (!rstn) begin
            mdl_reset();
        end else if (mdl_phase == 0) begin
            for (int k = 1; k <= NM; k++) begin
                c = (mdl_last + k) % NM;
                if (!found && m_psel[c]) begin
                    found     = 1'b1;
                    mdl_cur   = c;
                    mdl_last  = c;
                    mdl_phase = 1;
                end
            end
        end else if (mdl_phase == 1) begin
            mdl_phase = 2;
            mdl_wait  = 0;
        end else if (pready || mdl_timeout()) begin
            mdl_phase = 0;
            master_done(mdl_cur);
        end else begin
            mdl_wait++;
        end
    endtask

    task automatic cycle();
        check_cycle();
        mdl_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        mdl_reset();
        check_cycle();
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        rstn      = 1'b0;
        m_psel    = '0;
        m_penable = '0;
        m_pwrite  = '0;
        m_paddr   = '0;
        m_pwdata  = '0;
        for (int i = 0; i < NM; i++) remaining[i] = 0;
        set_slave(1'b0, 1'b0, 32'h0);
        #3;
        do_reset();

        // Single write from master 0, zero-wait slave
        order_q.delete();
        m_pwrite[0] = 1'b1; m_paddr[0] = 12'h004; m_pwdata[0] = 32'hDEADBEEF;
        remaining[0] = 1; m_psel[0] = 1'b1;
        set_slave(1'b1, 1'b0, 32'h0);
        cycle();
        #1;
        chk("s1_psel_c1",    64'(psel),    64'd1);
        chk("s1_penable_c1", 64'(penable), 64'd0);
        chk("s1_pwdata_c1",  64'(pwdata),  64'hDEADBEEF);
        cycle();
        #1;
        chk("s1_penable_c2", 64'(penable),  64'd1);
        chk("s1_mpready_c2", 64'(m_pready), 64'b001);
        cycle();
        chk("s1_psel_c3",    64'(psel),     64'd0);
        cycle();

        // Simultaneous requests straight after reset
        do_reset();
        order_q.delete(); done_q.delete();
        remaining[0] = 1; remaining[1] = 1;
        new_payload(0); new_payload(1);
        m_psel = 3'b011;
        for (int k = 0; k < 8; k++) cycle();
        chk("s2_count", 64'(order_q.size()), 64'd2);
        if (order_q.size() == 2) begin
            chk("s2_first",  64'(order_q[0]), 64'd0);
            chk("s2_second", 64'(order_q[1]), 64'd1);
            chk("s2_gap",    64'(done_q[1] - done_q[0]), 64'd3);
        end

        // Continuous contention between masters 0 and 1
        order_q.delete();
        remaining[0] = 3; remaining[1] = 3;
        new_payload(0); new_payload(1);
        m_psel = 3'b011;
        for (int k = 0; k < 20; k++) cycle();
        chk("s3_count", 64'(order_q.size()), 64'd6);
        for (int k = 0; k < 6 && k < order_q.size(); k++) begin
            chk("s3_order", 64'(order_q[k]), 64'(k % 2));
        end

        // Master 1 read with three wait states then an error response
        remaining[1] = 1;
        m_pwrite[1] = 1'b0; m_paddr[1] = 12'h0A8; m_pwdata[1] = $urandom;
        m_psel[1] = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k == 5) set_slave(1'b1, 1'b1, 32'h12345678);
            else        set_slave(1'b0, 1'b1, $urandom);
            #1;
            if (k == 4) chk("s4_no_err_wait", 64'(m_pslverr), 64'd0);
            if (k == 5) begin
                chk("s4_prdata", 64'(m_prdata),  64'h12345678);
                chk("s4_err",    64'(m_pslverr), 64'b010);
                chk("s4_ready",  64'(m_pready),  64'b010);
            end
            cycle();
        end

        // Granted master drops its select during SETUP
        remaining[0] = 1; new_payload(0); m_psel[0] = 1'b1;
        set_slave(1'b0, 1'b0, 32'h0);
        cycle();
        m_psel[0] = 1'b0;
        cycle();
        set_slave(1'b1, 1'b0, 32'h0);
        #1;
        chk("s5_still_done", 64'(m_pready), 64'b001);
        cycle();
        cycle();

`ifdef APB_ARB_TIMEOUT_EN
        // Slave never answers: the arbiter aborts on the limit-th wait cycle
        remaining[0] = 1; new_payload(0); m_psel[0] = 1'b1;
        set_slave(1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 7; k++) begin
            #1;
            if (k == 4) chk("s6_no_to_early", 64'(m_pready), 64'd0);
            if (k == 5) begin
                chk("s6_to_ready", 64'(m_pready),  64'b001);
                chk("s6_to_err",   64'(m_pslverr), 64'b001);
            end
            if (k == 6) chk("s6_psel_after", 64'(psel), 64'd0);
            cycle();
        end
`endif

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NM; i++) begin
                if (remaining[i] == 0 && $urandom_range(0, 3) == 0) begin
                    remaining[i] = $urandom_range(1, 3);
                    new_payload(i);
                    m_psel[i] = 1'b1;
                end
            end
            m_penable = NM'($urandom);
            set_slave(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            cycle();
        end

        // Reset asserted in the middle of an ACCESS phase
        for (int i = 0; i < NM; i++) begin
            remaining[i] = 0;
            m_psel[i] = 1'b0;
        end
        for (int k = 0; k < 4; k++) begin
            set_slave(1'b1, 1'b0, 32'h0);
            cycle();
        end
        order_q.delete();
        remaining[1] = 1; new_payload(1); m_psel[1] = 1'b1;
        set_slave(1'b0, 1'b0, 32'h0);
        cycle();
        cycle();
        remaining[0] = 1; new_payload(0); m_psel[0] = 1'b1;
        chk("s8_in_access", 64'(penable), 64'd1);
        set_slave(1'b1, 1'b0, 32'h0);
        rstn = 1'b0;
        #1;
        mdl_reset();
        chk("s8_rst_psel",    64'(psel),     64'd0);
        chk("s8_rst_penable", 64'(penable),  64'd0);
        chk("s8_rst_mpready", 64'(m_pready), 64'd0);
        check_cycle();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int k = 0; k < 8; k++) cycle();
        chk("s8_count", 64'(order_q.size()), 64'd2);
        if (order_q.size() == 2) begin
            chk("s8_first",  64'(order_q[0]), 64'd0);
            chk("s8_second", 64'(order_q[1]), 64'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
